// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared opcode/state types and helpers for the LC-3 core
package lc3_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h3000;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_MEM2    = 3'd4,
    S_WB      = 3'd5
  } state_e;

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  // {n,z,p} classification of a 16-bit two's-complement value
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

endpackage

// File: rtl/lc3_if.sv
// rtl/lc3_if.sv - instruction and data memory bus of the LC-3 core
interface lc3_if;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        Data_rd;
  logic        complete_data;

  modport master (
    output pc, instrmem_rd, Data_addr, Data_din, Data_rd,
    input  Instr_dout, complete_instr, Data_dout, complete_data
  );

  modport slave (
    input  pc, instrmem_rd, Data_addr, Data_din, Data_rd,
    output Instr_dout, complete_instr, Data_dout, complete_data
  );
endinterface

// File: rtl/lc3_fetch.sv
// rtl/lc3_fetch.sv - program counter and instruction fetch request
module lc3_fetch
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_updatePC,
  input  logic        enable_fetch,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic [15:0] pc,
  output logic [15:0] npc_out,
  output logic        instrmem_rd
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  assign pc      = pc_q;
  assign npc_out = pc_q + 16'd1;
  // The request is suppressed while reset is held even though the FSM sits in FETCH.
  assign instrmem_rd = enable_fetch & reset;

  // PC only moves in write-back: branch/jump target or the sequential address
  always_comb begin
    pc_d = pc_q;
    if (enable_updatePC) pc_d = br_taken ? taddr : npc_out;
  end

  // PC register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/lc3_core.sv
// rtl/lc3_core.sv - non-pipelined multi-cycle LC-3 core
module lc3_core
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic   clock,
  input logic   reset,
  lc3_if.master bus
);

  state_e      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] regs_q [8];
  logic [2:0]  nzp_q;
  logic [15:0] sr1_q, sr2_q, src_q;
  logic [15:0] alu_q, mdr_q, daddr_q, taddr_q;
  logic        br_taken_q;

  logic [15:0] pc, npc, pc_off9, base_off6, alu_res, mem_addr, tgt, wb_val;
  logic        instrmem_rd, taken;
  logic        is_mem, is_ind, is_load, writes_dr, sets_cc, store_access;
  opcode_e     op;

  assign op = opcode_e'(ir_q[15:12]);

  lc3_fetch #(.RESET_PC(RESET_PC)) Fetch (
    .clock           (clock),
    .reset           (reset),
    .enable_updatePC (state_q == S_WB),
    .enable_fetch    (state_q == S_FETCH),
    .br_taken        (br_taken_q),
    .taddr           (taddr_q),
    .pc              (pc),
    .npc_out         (npc),
    .instrmem_rd     (instrmem_rd)
  );

  assign is_mem    = op inside {OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI};
  assign is_ind    = op inside {OP_LDI, OP_STI};
  assign is_load   = op inside {OP_LD, OP_LDR, OP_LDI};
  assign sets_cc   = op inside {OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI};
  assign writes_dr = sets_cc | (op == OP_LEA);
  assign store_access = ((state_q == S_MEM)  && (op == OP_ST || op == OP_STR)) ||
                        ((state_q == S_MEM2) && (op == OP_STI));

  assign bus.pc          = pc;
  assign bus.instrmem_rd = instrmem_rd;
  assign bus.Data_addr   = daddr_q;
  assign bus.Data_rd     = ~store_access;
  assign bus.Data_din    = store_access ? src_q : 16'h0000;

  // Execute-stage ALU, effective address and branch resolution
  always_comb begin
    pc_off9   = npc + sext9(ir_q[8:0]);
    base_off6 = sr1_q + sext6(ir_q[5:0]);
    alu_res   = 16'h0000;
    mem_addr  = pc_off9;
    tgt       = pc_off9;
    taken     = 1'b0;
    case (op)
      OP_ADD: alu_res = sr1_q + (ir_q[5] ? sext5(ir_q[4:0]) : sr2_q);
      OP_AND: alu_res = sr1_q & (ir_q[5] ? sext5(ir_q[4:0]) : sr2_q);
      OP_NOT: alu_res = ~sr1_q;
      OP_LEA: alu_res = pc_off9;
      OP_LDR, OP_STR: mem_addr = base_off6;
      OP_JMP: begin
        tgt   = sr1_q;
        taken = 1'b1;
      end
      OP_BR:  taken = |(ir_q[11:9] & nzp_q);
      default: ;
    endcase
    wb_val = is_load ? mdr_q : alu_q;
  end

  // Next-state logic; memory states wait on complete_data
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (bus.complete_instr) state_d = S_DECODE;
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = is_mem ? S_MEM : S_WB;
      S_MEM:     if (bus.complete_data) state_d = is_ind ? S_MEM2 : S_WB;
      S_MEM2:    if (bus.complete_data) state_d = S_WB;
      S_WB:      state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Datapath registers, each loaded only in the state that owns it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q       <= 16'h0000;
      nzp_q      <= 3'b010;
      sr1_q      <= 16'h0000;
      sr2_q      <= 16'h0000;
      src_q      <= 16'h0000;
      alu_q      <= 16'h0000;
      mdr_q      <= 16'h0000;
      daddr_q    <= 16'h0000;
      taddr_q    <= 16'h0000;
      br_taken_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
    end else begin
      case (state_q)
        S_FETCH: if (bus.complete_instr) ir_q <= bus.Instr_dout;
        S_DECODE: begin
          sr1_q <= regs_q[ir_q[8:6]];
          sr2_q <= regs_q[ir_q[2:0]];
          src_q <= regs_q[ir_q[11:9]];
        end
        S_EXECUTE: begin
          alu_q      <= alu_res;
          taddr_q    <= tgt;
          br_taken_q <= taken;
          if (is_mem) daddr_q <= mem_addr;
        end
        S_MEM: if (bus.complete_data) begin
          mdr_q <= bus.Data_dout;
          if (is_ind) daddr_q <= bus.Data_dout;
        end
        S_MEM2: if (bus.complete_data) mdr_q <= bus.Data_dout;
        S_WB: begin
          if (writes_dr) regs_q[ir_q[11:9]] <= wb_val;
          if (sets_cc)   nzp_q <= nzp_of(wb_val);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_core.sv
// tb/tb_lc3_core.sv - directed self-checking bench for lc3_core
module tb_lc3_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ci = 1'b0;
  logic cd = 1'b1;
  logic [15:0] imem [16];
  logic [15:0] da0 = 16'h0, dd0 = 16'h0, da1 = 16'h0, dd1 = 16'h0;
  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [15:0] wr_addr = 16'h0, wr_data = 16'h0;

  always #5 clk = ~clk;

  lc3_if bus();

  lc3_core #(.RESET_PC(16'h3000)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  assign bus.Instr_dout     = imem[bus.pc[3:0]];
  assign bus.complete_instr = ci;
  assign bus.complete_data  = cd;
  assign bus.Data_dout = (bus.Data_addr == da0) ? dd0 :
                         (bus.Data_addr == da1) ? dd1 : 16'h0000;

  always @(negedge clk) begin
    if (rst_n && !bus.Data_rd && cd) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = bus.Data_addr;
      wr_data = bus.Data_din;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
    da0 = 16'h0; dd0 = 16'h0; da1 = 16'h0; dd1 = 16'h0;
  endtask

  task automatic do_reset(input logic ci_v, input logic cd_v);
    rst_n = 1'b0;
    ci = ci_v;
    cd = cd_v;
    repeat (2) @(negedge clk);
    wr_cnt = 0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_prog();
    rst_n = 1'b0;
    ci = 1'b1;
    cd = 1'b1;
    step(2);
    checks++; if (bus.pc !== 16'h3000) begin errors++; $display("FAIL rst_pc: got %h want 3000", bus.pc); end
    checks++; if (bus.instrmem_rd !== 1'b0) begin errors++; $display("FAIL rst_imrd: got %b want 0", bus.instrmem_rd); end
    checks++; if (bus.Data_rd !== 1'b1) begin errors++; $display("FAIL rst_drd: got %b want 1", bus.Data_rd); end
    checks++; if ({bus.Data_addr, bus.Data_din} !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", {bus.Data_addr, bus.Data_din}); end
    checks++; if (dut.nzp_q !== 3'b010) begin errors++; $display("FAIL rst_nzp: got %b want 010", dut.nzp_q); end
    checks++; if (dut.ir_q !== 16'h0 || dut.regs_q[7] !== 16'h0) begin errors++; $display("FAIL rst_ir_r7: got %h %h want 0 0", dut.ir_q, dut.regs_q[7]); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.instrmem_rd !== 1'b1 || bus.pc !== 16'h3000 || bus.Data_rd !== 1'b1) begin
      errors++; $display("FAIL first_fetch: got rd=%b pc=%h drd=%b want 1 3000 1", bus.instrmem_rd, bus.pc, bus.Data_rd);
    end
  endtask

  task automatic test_add_str();
    clear_prog();
    imem[0] = 16'h1225;
    imem[1] = 16'h7202;
    do_reset(1'b1, 1'b1);
    step(4);
    checks++; if (dut.regs_q[1] !== 16'h0005) begin errors++; $display("FAIL add_r1: got %h want 0005", dut.regs_q[1]); end
    checks++; if (dut.nzp_q !== 3'b001) begin errors++; $display("FAIL add_nzp: got %b want 001", dut.nzp_q); end
    checks++; if (bus.pc !== 16'h3001) begin errors++; $display("FAIL add_pc: got %h want 3001", bus.pc); end
    step(3);
    checks++; if (bus.Data_rd !== 1'b0 || bus.Data_din !== 16'h0005 || bus.Data_addr !== 16'h0002) begin
      errors++; $display("FAIL str_bus: got rd=%b din=%h addr=%h want 0 0005 0002", bus.Data_rd, bus.Data_din, bus.Data_addr);
    end
    checks++; if (bus.instrmem_rd !== 1'b0) begin errors++; $display("FAIL str_imrd: got %b want 0", bus.instrmem_rd); end
    step(2);
    checks++; if (wr_cnt !== 1 || bus.pc !== 16'h3002) begin errors++; $display("FAIL str_done: got wr=%0d pc=%h want 1 3002", wr_cnt, bus.pc); end
    checks++; if (bus.Data_rd !== 1'b1 || bus.Data_din !== 16'h0 || bus.Data_addr !== 16'h0002) begin
      errors++; $display("FAIL str_after: got rd=%b din=%h addr=%h want 1 0000 0002", bus.Data_rd, bus.Data_din, bus.Data_addr);
    end
  endtask

  task automatic test_branch();
    clear_prog();
    imem[0] = 16'h5020;
    imem[1] = 16'h0404;
    do_reset(1'b1, 1'b1);
    step(4);
    checks++; if (dut.nzp_q !== 3'b010 || bus.pc !== 16'h3001) begin errors++; $display("FAIL and_z: got nzp=%b pc=%h want 010 3001", dut.nzp_q, bus.pc); end
    step(3);
    checks++; if (dut.Fetch.br_taken !== 1'b1) begin errors++; $display("FAIL brz_taken: got %b want 1", dut.Fetch.br_taken); end
    step(1);
    checks++; if (bus.pc !== 16'h3006) begin errors++; $display("FAIL brz_pc: got %h want 3006", bus.pc); end
  endtask

  task automatic test_ld();
    clear_prog();
    imem[0] = 16'h2402;
    da0 = 16'h3003; dd0 = 16'h8000;
    do_reset(1'b1, 1'b1);
    step(3);
    checks++; if (bus.Data_addr !== 16'h3003 || bus.Data_rd !== 1'b1) begin errors++; $display("FAIL ld_bus: got addr=%h rd=%b want 3003 1", bus.Data_addr, bus.Data_rd); end
    step(2);
    checks++; if (dut.regs_q[2] !== 16'h8000 || dut.nzp_q !== 3'b100) begin errors++; $display("FAIL ld_r2: got %h nzp=%b want 8000 100", dut.regs_q[2], dut.nzp_q); end
    checks++; if (bus.pc !== 16'h3001) begin errors++; $display("FAIL ld_pc: got %h want 3001", bus.pc); end
  endtask

  task automatic test_sti();
    clear_prog();
    imem[0] = 16'h1225;
    imem[1] = 16'hB200;
    da0 = 16'h3002; dd0 = 16'h4000;
    do_reset(1'b1, 1'b1);
    step(7);
    checks++; if (bus.Data_addr !== 16'h3002 || bus.Data_rd !== 1'b1) begin errors++; $display("FAIL sti_ptr: got addr=%h rd=%b want 3002 1", bus.Data_addr, bus.Data_rd); end
    step(1);
    checks++; if (bus.Data_addr !== 16'h4000 || bus.Data_rd !== 1'b0 || bus.Data_din !== 16'h0005) begin
      errors++; $display("FAIL sti_wr: got addr=%h rd=%b din=%h want 4000 0 0005", bus.Data_addr, bus.Data_rd, bus.Data_din);
    end
    step(2);
    checks++; if (bus.pc !== 16'h3002 || wr_cnt !== 1 || wr_addr !== 16'h4000 || wr_data !== 16'h0005) begin
      errors++; $display("FAIL sti_done: got pc=%h wr=%0d %h %h want 3002 1 4000 0005", bus.pc, wr_cnt, wr_addr, wr_data);
    end
  endtask

  task automatic test_nop_jmp();
    clear_prog();
    imem[0] = 16'h0005;
    imem[1] = 16'h4000;
    imem[2] = 16'hEE03;
    imem[3] = 16'hC1C0;
    imem[6] = 16'h97FF;
    do_reset(1'b1, 1'b1);
    step(3);
    checks++; if (dut.Fetch.br_taken !== 1'b0) begin errors++; $display("FAIL br000_taken: got %b want 0", dut.Fetch.br_taken); end
    step(5);
    checks++; if (bus.pc !== 16'h3002) begin errors++; $display("FAIL jsr_nop_pc: got %h want 3002", bus.pc); end
    step(4);
    checks++; if (dut.regs_q[7] !== 16'h3006 || dut.nzp_q !== 3'b010) begin errors++; $display("FAIL lea: got r7=%h nzp=%b want 3006 010", dut.regs_q[7], dut.nzp_q); end
    step(4);
    checks++; if (bus.pc !== 16'h3006) begin errors++; $display("FAIL jmp_pc: got %h want 3006", bus.pc); end
    step(4);
    checks++; if (dut.regs_q[3] !== 16'hCFF9 || dut.nzp_q !== 3'b100 || bus.pc !== 16'h3007) begin
      errors++; $display("FAIL not: got r3=%h nzp=%b pc=%h want CFF9 100 3007", dut.regs_q[3], dut.nzp_q, bus.pc);
    end
  endtask

  task automatic test_stall();
    clear_prog();
    imem[0] = 16'h2402;
    da0 = 16'h3003; dd0 = 16'h7FFF;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++; if (bus.pc !== 16'h3000 || bus.instrmem_rd !== 1'b1 || bus.Data_addr !== 16'h0 || bus.Data_rd !== 1'b1) begin
        errors++; $display("FAIL istall_%0d: got pc=%h rd=%b addr=%h drd=%b", i, bus.pc, bus.instrmem_rd, bus.Data_addr, bus.Data_rd);
      end
    end
    ci = 1'b1;
    step(2);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (bus.pc !== 16'h3000 || bus.instrmem_rd !== 1'b0 || bus.Data_addr !== 16'h3003 || bus.Data_rd !== 1'b1) begin
        errors++; $display("FAIL dstall_%0d: got pc=%h rd=%b addr=%h drd=%b", i, bus.pc, bus.instrmem_rd, bus.Data_addr, bus.Data_rd);
      end
    end
    cd = 1'b1;
    step(2);
    checks++; if (dut.regs_q[2] !== 16'h7FFF || dut.nzp_q !== 3'b001 || bus.pc !== 16'h3001) begin
      errors++; $display("FAIL stall_done: got r2=%h nzp=%b pc=%h want 7FFF 001 3001", dut.regs_q[2], dut.nzp_q, bus.pc);
    end
  endtask

  task automatic test_reset_abort();
    clear_prog();
    imem[0] = 16'h1225;
    imem[1] = 16'hB200;
    da0 = 16'h3002; dd0 = 16'h4000;
    do_reset(1'b1, 1'b1);
    step(7);
    rst_n = 1'b0;
    step(2);
    checks++; if (wr_cnt !== 0 || dut.regs_q[1] !== 16'h0 || bus.pc !== 16'h3000 || bus.Data_rd !== 1'b1) begin
      errors++; $display("FAIL abort: got wr=%0d r1=%h pc=%h drd=%b want 0 0000 3000 1", wr_cnt, dut.regs_q[1], bus.pc, bus.Data_rd);
    end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.pc !== 16'h3000 || bus.instrmem_rd !== 1'b1) begin errors++; $display("FAIL abort_refetch: got pc=%h rd=%b want 3000 1", bus.pc, bus.instrmem_rd); end
    step(4);
    checks++; if (dut.regs_q[1] !== 16'h0005 || bus.pc !== 16'h3001) begin errors++; $display("FAIL abort_rerun: got r1=%h pc=%h want 0005 3001", dut.regs_q[1], bus.pc); end
  endtask

  initial begin
    test_reset();
    test_add_str();
    test_branch();
    test_ld();
    test_sti();
    test_nop_jmp();
    test_stall();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_core.md
LC3_CORE -- requirements
Module: lc3_core

Interface
REQ-001 Parameter RESET_PC, default 16'h3000, address of the first instruction fetched after reset.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pc  output  16  instruction memory address.
REQ-005 instrmem_rd  output  1  instruction read request.
REQ-006 Instr_dout  input  16  instruction word from instruction memory.
REQ-007 complete_instr  input  1  instruction memory done; Instr_dout valid.
REQ-008 Data_addr  output  16  data memory address.
REQ-009 Data_din  output  16  store data to data memory.
REQ-010 Data_dout  input  16  load data from data memory.
REQ-011 Data_rd  output  1  1 = read, 0 = write.
REQ-012 complete_data  input  1  data memory access done.

Function
REQ-013 Non-pipelined multi-cycle LC-3 core with states FETCH, DECODE, EXECUTE, MEM, MEM2 and WB.
REQ-014 FETCH: instrmem_rd=1 and pc is held; on complete_instr=1, latch Instr_dout into IR and go to DECODE; otherwise stay in FETCH.
REQ-015 DECODE (1 cycle): read the register file and compute npc=pc+1; go to EXECUTE.
REQ-016 EXECUTE (1 cycle): ALU and address computation; LD/LDR/LDI/ST/STR/STI go to MEM, all others go to WB.
REQ-017 MEM: drive Data_addr, Data_rd and Data_din; hold until complete_data=1, then capture Data_dout.
REQ-018 LDI/STI use MEM for the pointer read, then MEM2 for the final access at the captured pointer; all other memory ops go from MEM to WB.
REQ-019 WB: write the destination register, update NZP, pulse enable_updatePC for 1 cycle, then go to FETCH.
REQ-020 Instruction latency is 4 cycles (ALU, BR, JMP, LEA), 5 cycles (LD/LDR/ST/STR) or 6 cycles (LDI/STI), with zero memory wait.
REQ-021 PC update in WB: pc <= br_taken ? taddr : npc.
REQ-022 ADD/AND: SR1 op (bit5 ? sext(imm5) : SR2); NOT: ~SR1; all arithmetic is 16-bit, wrap-around, no flags other than NZP.
REQ-023 Address rules: BR/LD/ST/LDI/STI/LEA use npc+sext(PCoffset9); LDR/STR use BaseR+sext(offset6); JMP uses BaseR (RET = JMP R7).
REQ-024 br_taken=1 for JMP, and for BR when (n&N)|(z&Z)|(p&P); BR with nzp=000 is never taken.
REQ-025 NZP is set from the written value by ADD, AND, NOT, LD, LDR and LDI; LEA writes DR but does not change NZP.
REQ-026 Opcodes JSR, TRAP, RTI and 1101 execute as NOPs (pc <= npc).
REQ-027 Data_rd=0 only in the store access state (MEM for ST/STR, MEM2 for STI); it is 1 at all other times.
REQ-028 Data_din = SR register value during stores, otherwise 0.
REQ-029 Data_addr holds its last value outside MEM/MEM2.
REQ-030 instrmem_rd=0 outside FETCH.
REQ-031 A stalled handshake (complete_* held 0) holds all outputs stable indefinitely.

Reset
REQ-032 While reset=0: pc=RESET_PC, state=FETCH, R0-R7=0, NZP=3'b010, IR=0, Data_addr=0, Data_din=0, Data_rd=1, instrmem_rd=0.
REQ-033 Reset assertion mid-instruction aborts it with no register or memory write; the first fetch after release is at RESET_PC.

Structure
REQ-034 Shared package lc3_pkg: opcode enum, state enum, and RESET_PC default.
REQ-035 One sub-module lc3_fetch, instance name Fetch, holding signals enable_updatePC, enable_fetch, pc, npc_out (=pc+1), instrmem_rd, taddr and br_taken with exactly these names for hierarchical probing.

Verification
REQ-036 Reset release, complete_instr=1 -> pc=16'h3000, instrmem_rd=1 in the first cycle, Data_rd=1.
REQ-037 0x1225 (ADD R1,R0,#5) at 3000 -> R1=5, NZP=001, pc=3001 after 4 cycles; confirm R1 by a following STR writing Data_din=0005.
REQ-038 0x5020 (AND R0,R0,#0) then 0x0404 (BRz #4) at 3001 -> Z set, br_taken=1, pc=3006.
REQ-039 0x2402 (LD R2,#2) at 3000 -> Data_addr=3003, Data_rd=1; Data_dout=8000 -> R2=8000, NZP=100.
REQ-040 0xB201 (STI R1,#1) at 3000 with R1=0005 -> read of 3002 returns 4000, then write with Data_addr=4000, Data_rd=0, Data_din=0005.
REQ-041 complete_instr held 0 for 5 cycles, then complete_data held 0 for 3 cycles -> pc, instrmem_rd and Data_* stay stable during each stall, and the instruction completes correctly afterwards.
